// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: carries D->X->W instruction registers, emits X-stage forward selects,
// load-use stall, D flush, and saturating stall/flush perf counters. Comb outputs, 1-cycle stage advance.
// Backpressure: i_mem_stall freezes all stage registers and counter increments.
module hazard_scoreboard #(
    parameter int          CNT_WIDTH = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [31:0]          i_d_instruction,
    input  logic                 i_d_valid,
    input  logic                 i_redirect,
    input  logic                 i_mem_stall,
    input  logic                 i_cnt_clr,
    output logic [31:0]          o_x_instruction,
    output logic [31:0]          o_wf_instruction,
    output logic                 o_fwd_a_sel,
    output logic                 o_fwd_b_sel,
    output logic                 o_stall_fd,
    output logic                 o_nop_sel,
    output logic [CNT_WIDTH-1:0] o_stall_cnt,
    output logic [CNT_WIDTH-1:0] o_flush_cnt
);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    function automatic logic f_writes_rd(input logic [4:0] opc, input logic [4:0] rd,
                                         input logic vld);
        return vld && (opc != OPC_BRANCH) && (opc != OPC_STORE) && (rd != 5'd0);
    endfunction

    function automatic logic f_uses_rs1(input logic [4:0] opc);
        return (opc != OPC_LUI) && (opc != OPC_AUIPC) && (opc != OPC_JAL);
    endfunction

    function automatic logic f_uses_rs2(input logic [4:0] opc);
        return (opc == OPC_OP) || (opc == OPC_BRANCH) || (opc == OPC_STORE);
    endfunction

    logic [31:0]          r_x_instr;
    logic                 r_x_vld;
    logic [31:0]          r_w_instr;
    logic                 r_w_vld;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    logic [4:0] w_d_opc, w_d_rs1, w_d_rs2;
    logic [4:0] w_x_opc, w_x_rd, w_x_rs1, w_x_rs2;
    logic [4:0] w_w_opc, w_w_rd;
    logic       w_load_use;
    logic       w_w_writes;
    logic       w_x_bubble;
    logic       w_stall_inc;
    logic       w_flush_inc;

    assign w_d_opc = i_d_instruction[6:2];
    assign w_d_rs1 = i_d_instruction[19:15];
    assign w_d_rs2 = i_d_instruction[24:20];
    assign w_x_opc = r_x_instr[6:2];
    assign w_x_rd  = r_x_instr[11:7];
    assign w_x_rs1 = r_x_instr[19:15];
    assign w_x_rs2 = r_x_instr[24:20];
    assign w_w_opc = r_w_instr[6:2];
    assign w_w_rd  = r_w_instr[11:7];

    // A redirect squashes D, so a load-use against it would only waste a cycle.
    assign w_load_use = r_x_vld && (w_x_opc == OPC_LOAD) && (w_x_rd != 5'd0) &&
                        i_d_valid && !i_redirect &&
                        ((f_uses_rs1(w_d_opc) && (w_d_rs1 == w_x_rd)) ||
                         (f_uses_rs2(w_d_opc) && (w_d_rs2 == w_x_rd)));

    assign w_w_writes  = f_writes_rd(w_w_opc, w_w_rd, r_w_vld);
    assign o_fwd_a_sel = w_w_writes && f_uses_rs1(w_x_opc) && (w_w_rd == w_x_rs1);
    assign o_fwd_b_sel = w_w_writes && f_uses_rs2(w_x_opc) && (w_w_rd == w_x_rs2);
    assign o_stall_fd  = w_load_use || i_mem_stall;
    assign o_nop_sel   = i_redirect;

    assign w_x_bubble  = i_redirect || w_load_use || !i_d_valid;
    assign w_stall_inc = w_load_use && !i_mem_stall && !(&r_stall_cnt);
    assign w_flush_inc = i_redirect && !i_mem_stall && !(&r_flush_cnt);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x_instr   <= NOP_INSTR;
            r_x_vld     <= 1'b0;
            r_w_instr   <= NOP_INSTR;
            r_w_vld     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!i_mem_stall) begin
                r_w_instr <= r_x_instr;
                r_w_vld   <= r_x_vld;
                r_x_instr <= w_x_bubble ? NOP_INSTR : i_d_instruction;
                r_x_vld   <= !w_x_bubble;
            end
            // Clear beats a same-cycle increment.
            if (i_cnt_clr) begin
                r_stall_cnt <= '0;
                r_flush_cnt <= '0;
            end else begin
                if (w_stall_inc) r_stall_cnt <= r_stall_cnt + 1'b1;
                if (w_flush_inc) r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign o_x_instruction  = r_x_instr;
    assign o_wf_instruction = r_w_instr;
    assign o_stall_cnt      = r_stall_cnt;
    assign o_flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed protocol scenarios then randomized traffic,
// every output compared each cycle against a pipeline reference model.
module tb_hazard_scoreboard;
    localparam int          CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   d_ins = NOP;
    logic          d_vld = 1'b0, redir = 1'b0, mstall = 1'b0, clr = 1'b0;
    logic [31:0]   x_ins, w_ins;
    logic          fa, fb, stl, nsel;
    logic [CW-1:0] scnt, fcnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(.CNT_WIDTH(CW), .NOP_INSTR(NOP)) dut (
        .i_clk(clk), .i_rst(rst), .i_d_instruction(d_ins), .i_d_valid(d_vld),
        .i_redirect(redir), .i_mem_stall(mstall), .i_cnt_clr(clr),
        .o_x_instruction(x_ins), .o_wf_instruction(w_ins),
        .o_fwd_a_sel(fa), .o_fwd_b_sel(fb), .o_stall_fd(stl), .o_nop_sel(nsel),
        .o_stall_cnt(scnt), .o_flush_cnt(fcnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pipe[0] is the X stage, pipe[1] the W stage.
    typedef struct {
        logic [31:0] ins;
        bit          vld;
    } stage_t;
    stage_t pipe [2];
    int     m_sc, m_fc;

    function automatic logic [31:0] rtype(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] lw(input int rd, input int rs1);
        return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'(imm), 7'b0100011};
    endfunction

    function automatic int opc(input logic [31:0] i);  return int'(i[6:2]);   endfunction
    function automatic int rdf(input logic [31:0] i);  return int'(i[11:7]);  endfunction
    function automatic int rs1f(input logic [31:0] i); return int'(i[19:15]); endfunction
    function automatic int rs2f(input logic [31:0] i); return int'(i[24:20]); endfunction

    function automatic bit writes(input stage_t s);
        return s.vld && opc(s.ins) != 24 && opc(s.ins) != 8 && rdf(s.ins) != 0;
    endfunction
    function automatic bit reads1(input logic [31:0] i);
        return !(opc(i) inside {13, 5, 27});
    endfunction
    function automatic bit reads2(input logic [31:0] i);
        return opc(i) inside {12, 24, 8};
    endfunction

    function automatic bit exp_lu();
        int lrd = rdf(pipe[0].ins);
        if (!(pipe[0].vld && opc(pipe[0].ins) == 0 && lrd != 0 && d_vld && !redir)) return 0;
        return (reads1(d_ins) && rs1f(d_ins) == lrd) || (reads2(d_ins) && rs2f(d_ins) == lrd);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cmp_all();
        bit lu = exp_lu();
        check("x_instr", x_ins, pipe[0].ins);
        check("w_instr", w_ins, pipe[1].ins);
        check("fwd_a", 32'(fa), 32'(writes(pipe[1]) && reads1(pipe[0].ins) &&
                                      rdf(pipe[1].ins) == rs1f(pipe[0].ins)));
        check("fwd_b", 32'(fb), 32'(writes(pipe[1]) && reads2(pipe[0].ins) &&
                                      rdf(pipe[1].ins) == rs2f(pipe[0].ins)));
        check("stall_fd", 32'(stl), 32'(lu || mstall));
        check("nop_sel", 32'(nsel), 32'(redir));
        check("stall_cnt", 32'(scnt), 32'(m_sc));
        check("flush_cnt", 32'(fcnt), 32'(m_fc));
    endtask

    task automatic drive(input logic [31:0] di, input bit dv, input bit rdr, input bit ms,
                         input bit cl, input bit r);
        @(negedge clk);
        d_ins = di; d_vld = dv; redir = rdr; mstall = ms; clr = cl; rst = r;
        #1;
        cmp_all();
    endtask

    task automatic tick();
        bit lu = exp_lu();
        @(posedge clk);
        if (rst) begin
            pipe[0] = '{NOP, 0}; pipe[1] = '{NOP, 0}; m_sc = 0; m_fc = 0;
        end else begin
            if (!mstall) begin
                pipe[1] = pipe[0];
                if (redir || lu || !d_vld) pipe[0] = '{NOP, 0};
                else                       pipe[0] = '{d_ins, 1};
            end
            if (clr) begin
                m_sc = 0; m_fc = 0;
            end else if (!mstall) begin
                if (lu && m_sc < CMAX)    m_sc++;
                if (redir && m_fc < CMAX) m_fc++;
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [8] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011,
                                 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111};
        logic [31:0] i = $urandom;
        i[6:0]   = ops[$urandom_range(0, 7)];
        i[11:7]  = 5'($urandom_range(0, 3));
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        return i;
    endfunction

    initial begin
        pipe[0] = '{NOP, 0}; pipe[1] = '{NOP, 0}; m_sc = 0; m_fc = 0;
        tick(); tick();

        // reset state
        drive(NOP, 0, 0, 0, 0, 0);
        check("rst_x", x_ins, NOP);
        check("rst_w", w_ins, NOP);
        check("rst_comb", {28'd0, fa, fb, stl, nsel}, 32'd0);
        tick();

        // ALU -> ALU forward on rs1 only
        drive(rtype(5, 1, 2), 1, 0, 0, 0, 0); tick();
        drive(rtype(6, 5, 3), 1, 0, 0, 0, 0); tick();
        drive(NOP, 0, 0, 0, 0, 0);
        check("t1_fa", 32'(fa), 32'd1);
        check("t1_fb", 32'(fb), 32'd0);
        check("t1_stall", 32'(stl), 32'd0);
        tick();

        // load-use: one bubble, load then visible in W
        drive(lw(7, 1), 1, 0, 0, 0, 0); tick();
        drive(rtype(8, 7, 7), 1, 0, 0, 0, 0);
        check("t2_stall", 32'(stl), 32'd1);
        tick();
        drive(rtype(8, 7, 7), 1, 0, 0, 0, 0);
        check("t2_bubble", x_ins, NOP);
        check("t2_w_load", w_ins, lw(7, 1));
        check("t2_scnt", 32'(scnt), 32'd1);
        check("t2_no_restall", 32'(stl), 32'd0);
        tick();
        drive(NOP, 0, 0, 0, 0, 0);
        check("t2_x_add", x_ins, rtype(8, 7, 7));
        tick();

        // x0 destination and stores never hazard
        drive(lw(0, 1), 1, 0, 0, 0, 0); tick();
        drive(rtype(8, 0, 0), 1, 0, 0, 0, 0);
        check("t3_x0_nostall", 32'(stl), 32'd0);
        tick();
        drive(sw(5, 1, 5), 1, 0, 0, 0, 0);
        check("t3_x0_nofwd", {30'd0, fa, fb}, 32'd0);
        tick();
        drive(rtype(9, 5, 5), 1, 0, 0, 0, 0); tick();
        drive(NOP, 0, 0, 0, 0, 0);
        check("t3_sw_nofwd", {30'd0, fa, fb}, 32'd0);
        tick();

        // redirect overrides a pending load-use
        drive(lw(7, 1), 1, 0, 0, 0, 0); tick();
        drive(rtype(8, 7, 7), 1, 1, 0, 0, 0);
        check("t4_nop_sel", 32'(nsel), 32'd1);
        check("t4_stall", 32'(stl), 32'd0);
        tick();
        drive(NOP, 0, 0, 0, 0, 0);
        check("t4_x_nop", x_ins, NOP);
        check("t4_fcnt", 32'(fcnt), 32'd1);
        tick();

        // mem_stall freeze across a load-use
        drive(lw(7, 1), 1, 0, 0, 0, 0); tick();
        repeat (3) begin
            drive(rtype(8, 7, 7), 1, 0, 1, 0, 0);
            check("t5_frozen_x", x_ins, lw(7, 1));
            check("t5_frozen_scnt", 32'(scnt), 32'd1);
            tick();
        end
        drive(rtype(8, 7, 7), 1, 0, 0, 0, 0); tick();
        drive(NOP, 0, 0, 0, 0, 0);
        check("t5_scnt", 32'(scnt), 32'd2);
        tick();

        // saturation and clear
        repeat (16) begin
            drive(lw(7, 1), 1, 0, 0, 0, 0); tick();
            drive(rtype(8, 7, 7), 1, 0, 0, 0, 0); tick();
        end
        repeat (16) begin
            drive(NOP, 1, 1, 0, 0, 0); tick();
        end
        drive(NOP, 0, 0, 0, 0, 0);
        check("t6_scnt_sat", 32'(scnt), 32'(CMAX));
        check("t6_fcnt_sat", 32'(fcnt), 32'(CMAX));
        tick();
        drive(NOP, 0, 0, 0, 1, 0); tick();
        drive(NOP, 1, 1, 0, 1, 0);
        check("t6_clr_s", 32'(scnt), 32'd0);
        check("t6_clr_f", 32'(fcnt), 32'd0);
        tick();
        drive(NOP, 0, 0, 0, 0, 0);
        check("t6_clr_wins", 32'(fcnt), 32'd0);
        tick();

        // reset mid-stream
        drive(lw(7, 1), 1, 1, 0, 0, 0); tick();
        drive(lw(7, 1), 1, 0, 0, 0, 0); tick();
        drive(rtype(8, 7, 7), 1, 0, 0, 0, 1); tick();
        drive(NOP, 0, 0, 0, 0, 0);
        check("mid_rst_x", x_ins, NOP);
        check("mid_rst_cnt", {24'd0, scnt, fcnt}, 32'd0);
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit ms = ($urandom_range(0, 99) < 15);
            drive(rand_instr(), $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 15, ms,
                  !ms && ($urandom_range(0, 99) < 2), $urandom_range(0, 199) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
